// File: rtl/cache_evict_buffer.sv
// rtl/cache_evict_buffer.sv - dirty-victim writeback FIFO draining cache lines as bus beat bursts
// Captures the selected victim way on a dirty miss and replays it to the bus beat by beat.
module cache_evict_buffer #(
  parameter int NUMWAYS = 4,
  parameter int SETLEN  = 7,
  parameter int TAGLEN  = 43,
  parameter int LINELEN = 512,
  parameter int BEATLEN = 64,
  parameter int DEPTH   = 2
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       CaptureEn,
  input  logic [NUMWAYS-1:0]                         VictimWay,
  input  logic [NUMWAYS-1:0]                         DirtyWay,
  input  logic [NUMWAYS*TAGLEN-1:0]                  TagWay,
  input  logic [NUMWAYS*LINELEN-1:0]                 ReadDataWay,
  input  logic [SETLEN-1:0]                          CacheSet,
  input  logic [TAGLEN+SETLEN-1:0]                   LookupAdr,
  output logic                                       EvictReady,
  output logic                                       Hazard,
  output logic                                       Overflow,
  output logic                                       BusValid,
  input  logic                                       BusReady,
  output logic [TAGLEN+SETLEN+$clog2(LINELEN/8)-1:0] BusAdr,
  output logic [BEATLEN-1:0]                         BusData,
  output logic                                       BusLast
);

  localparam int BEATS = LINELEN / BEATLEN;
  localparam int BW    = $clog2(BEATS);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int OFF   = $clog2(LINELEN / 8);
  localparam int ADRW  = TAGLEN + SETLEN + OFF;
  localparam int LOW   = OFF - BW;

  logic [CW-1:0]      count_q, count_d;
  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [TAGLEN-1:0]  tag_q  [DEPTH];
  logic [TAGLEN-1:0]  tag_d  [DEPTH];
  logic [SETLEN-1:0]  set_q  [DEPTH];
  logic [SETLEN-1:0]  set_d  [DEPTH];
  logic [LINELEN-1:0] line_q [DEPTH];
  logic [LINELEN-1:0] line_d [DEPTH];

  logic               full, cap, push, xfer, pop;
  logic [TAGLEN-1:0]  sel_tag;
  logic [LINELEN-1:0] sel_line;

  // AND-OR mux: the one-hot victim selects its way's tag and line
  always_comb begin
    sel_tag  = '0;
    sel_line = '0;
    for (int w = 0; w < NUMWAYS; w++) begin
      sel_tag  = sel_tag  | (TagWay[w*TAGLEN +: TAGLEN] & {TAGLEN{VictimWay[w]}});
      sel_line = sel_line | (ReadDataWay[w*LINELEN +: LINELEN] & {LINELEN{VictimWay[w]}});
    end
  end

  always_comb begin
    full       = (count_q == CW'(DEPTH));
    cap        = CaptureEn & (|(VictimWay & DirtyWay));
    push       = cap & ~full;
    Overflow   = cap & full;
    EvictReady = ~full;
    BusValid   = (count_q != '0);
    BusLast    = (beat_q == BW'(BEATS - 1));
    BusData    = line_q[head_q][beat_q*BEATLEN +: BEATLEN];
    BusAdr     = (ADRW'({tag_q[head_q], set_q[head_q]}) << OFF) | (ADRW'(beat_q) << LOW);
    xfer       = BusValid & BusReady;
    pop        = xfer & BusLast;
  end

  always_comb begin
    Hazard = 1'b0;
    for (int d = 0; d < DEPTH; d++) begin
      if (valid_q[d] && ({tag_q[d], set_q[d]} == LookupAdr)) Hazard = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    beat_d  = xfer ? beat_q + 1'b1 : beat_q;
    valid_d = valid_q;
    for (int d = 0; d < DEPTH; d++) begin
      tag_d[d]  = tag_q[d];
      set_d[d]  = set_q[d];
      line_d[d] = line_q[d];
    end
    if (pop) valid_d[head_q] = 1'b0;
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tag_d[tail_q]   = sel_tag;
      set_d[tail_q]   = CacheSet;
      line_d[tail_q]  = sel_line;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      beat_q  <= '0;
      valid_q <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage is qualified by valid_q, so it is left unreset
  always_ff @(posedge clk) begin
    for (int d = 0; d < DEPTH; d++) begin
      tag_q[d]  <= tag_d[d];
      set_q[d]  <= set_d[d];
      line_q[d] <= line_d[d];
    end
  end

endmodule

// File: tb/tb_cache_evict_buffer.sv
// tb/tb_cache_evict_buffer.sv - directed plus random bench for cache_evict_buffer against a queue model
module tb_cache_evict_buffer;

  localparam int NUMWAYS = 4;
  localparam int SETLEN  = 7;
  localparam int TAGLEN  = 43;
  localparam int LINELEN = 512;
  localparam int BEATLEN = 64;
  localparam int DEPTH   = 2;
  localparam int BEATS   = LINELEN / BEATLEN;
  localparam int OFF     = $clog2(LINELEN / 8);
  localparam int ADRW    = TAGLEN + SETLEN + OFF;

  logic                          clk = 1'b0;
  logic                          reset = 1'b1;
  logic                          CaptureEn = 1'b0;
  logic [NUMWAYS-1:0]            VictimWay = '0;
  logic [NUMWAYS-1:0]            DirtyWay = '0;
  logic [NUMWAYS*TAGLEN-1:0]     TagWay = '0;
  logic [NUMWAYS*LINELEN-1:0]    ReadDataWay = '0;
  logic [SETLEN-1:0]             CacheSet = '0;
  logic [TAGLEN+SETLEN-1:0]      LookupAdr = '0;
  logic                          EvictReady, Hazard, Overflow, BusValid, BusLast;
  logic                          BusReady = 1'b0;
  logic [ADRW-1:0]               BusAdr;
  logic [BEATLEN-1:0]            BusData;

  int errors = 0;
  int checks = 0;

  logic [TAGLEN-1:0]  q_tag  [$];
  logic [SETLEN-1:0]  q_set  [$];
  logic [LINELEN-1:0] q_line [$];
  int                 m_beat = 0;
  bit                 known  = 0;

  cache_evict_buffer #(
    .NUMWAYS(NUMWAYS), .SETLEN(SETLEN), .TAGLEN(TAGLEN),
    .LINELEN(LINELEN), .BEATLEN(BEATLEN), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .CaptureEn(CaptureEn), .VictimWay(VictimWay),
    .DirtyWay(DirtyWay), .TagWay(TagWay), .ReadDataWay(ReadDataWay),
    .CacheSet(CacheSet), .LookupAdr(LookupAdr), .EvictReady(EvictReady),
    .Hazard(Hazard), .Overflow(Overflow), .BusValid(BusValid), .BusReady(BusReady),
    .BusAdr(BusAdr), .BusData(BusData), .BusLast(BusLast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fill all ways with random data; ways flagged in vw get the given tag
  task automatic set_cap(input logic [3:0] vw, input logic [3:0] dw,
                         input logic [TAGLEN-1:0] tag, input logic [SETLEN-1:0] set);
    for (int i = 0; i < NUMWAYS*LINELEN/32; i++) ReadDataWay[i*32 +: 32] = $urandom();
    for (int w = 0; w < NUMWAYS; w++) begin
      TagWay[w*TAGLEN +: TAGLEN] = vw[w] ? tag : TAGLEN'($urandom_range(0, 7));
    end
    VictimWay = vw;
    DirtyWay  = dw;
    CacheSet  = set;
    CaptureEn = 1'b1;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model across the edge
  task automatic cyc();
    bit cap, full, hz;
    int vidx;
    logic [ADRW-1:0]    exp_adr;
    logic [LINELEN-1:0] sh;
    @(negedge clk);
    full = (q_tag.size() == DEPTH);
    cap  = CaptureEn && ((VictimWay & DirtyWay) != 0);
    hz   = 0;
    foreach (q_tag[i]) if ({q_tag[i], q_set[i]} == LookupAdr) hz = 1;
    if (known) begin
      chk("bus_valid", 64'(BusValid), 64'(q_tag.size() != 0));
      chk("evict_ready", 64'(EvictReady), 64'(!full));
      chk("overflow", 64'(Overflow), 64'(cap && full));
      chk("hazard", 64'(Hazard), 64'(hz));
      if (q_tag.size() != 0) begin
        exp_adr = (ADRW'({q_tag[0], q_set[0]}) << OFF) + ADRW'(m_beat * (BEATLEN/8));
        sh = q_line[0] >> (m_beat * BEATLEN);
        chk("bus_adr", 64'(BusAdr), 64'(exp_adr));
        chk("bus_data", BusData, sh[BEATLEN-1:0]);
        chk("bus_last", 64'(BusLast), 64'(m_beat == BEATS-1));
      end
    end
    if (reset) begin
      q_tag.delete(); q_set.delete(); q_line.delete();
      m_beat = 0;
      known  = 1;
    end else if (known) begin
      if (BusReady && q_tag.size() != 0) begin
        if (m_beat == BEATS-1) begin
          void'(q_tag.pop_front()); void'(q_set.pop_front()); void'(q_line.pop_front());
          m_beat = 0;
        end else begin
          m_beat++;
        end
      end
      if (cap && !full) begin
        vidx = 0;
        for (int w = 0; w < NUMWAYS; w++) if (VictimWay[w]) vidx = w;
        q_tag.push_back(TagWay[vidx*TAGLEN +: TAGLEN]);
        q_set.push_back(CacheSet);
        q_line.push_back(ReadDataWay[vidx*LINELEN +: LINELEN]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    // reset
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    chk("rst_valid", 64'(BusValid), 64'd0);
    chk("rst_ready", 64'(EvictReady), 64'd1);

    // 1: single dirty capture, full burst drain
    BusReady = 1'b1;
    set_cap(4'b0100, 4'b0100, TAGLEN'(43'h1A), 7'd5);
    cyc();
    CaptureEn = 1'b0;
    chk("t1_adr", 64'(BusAdr), 64'({43'h1A, 7'd5, 6'd0}));
    chk("t1_valid", 64'(BusValid), 64'd1);
    for (int i = 0; i < BEATS; i++) cyc();
    chk("t1_drained", 64'(BusValid), 64'd0);

    // 2: clean victim
    set_cap(4'b0010, 4'b1101, TAGLEN'(43'h22), 7'd3);
    cyc();
    CaptureEn = 1'b0;
    chk("t2_valid", 64'(BusValid), 64'd0);

    // 3: fill with bus stalled, third capture overflows
    BusReady = 1'b0;
    set_cap(4'b0001, 4'b0001, TAGLEN'(43'h100), 7'd1);
    cyc();
    set_cap(4'b1000, 4'b1001, TAGLEN'(43'h200), 7'd2);
    cyc();
    chk("t3_full", 64'(EvictReady), 64'd0);
    set_cap(4'b0010, 4'b0010, TAGLEN'(43'h300), 7'd3);
    cyc();
    CaptureEn = 1'b0;
    cyc();

    // 4: full, capture coincident with final beat is dropped
    BusReady = 1'b1;
    for (int i = 0; i < BEATS-1; i++) cyc();
    set_cap(4'b0100, 4'b0100, TAGLEN'(43'h400), 7'd4);
    cyc();
    CaptureEn = 1'b0;
    chk("t4_ready", 64'(EvictReady), 64'd1);

    // 5: count 1, capture with final-beat pop
    for (int i = 0; i < BEATS-1; i++) cyc();
    set_cap(4'b1000, 4'b1000, TAGLEN'(43'h555), 7'd6);
    cyc();
    CaptureEn = 1'b0;
    chk("t5_new_adr", 64'(BusAdr), 64'({43'h555, 7'd6, 6'd0}));

    // 6: hazard on the draining line, reset mid-burst
    LookupAdr = {43'h555, 7'd6};
    cyc();
    cyc();
    cyc();
    chk("t6_hazard", 64'(Hazard), 64'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t6_rst_valid", 64'(BusValid), 64'd0);
    chk("t6_rst_hazard", 64'(Hazard), 64'd0);
    cyc();

    // random traffic with small tag/set pools so hazards occur
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] vw;
      vw = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'(1 << $urandom_range(0, 3));
      set_cap(vw, 4'($urandom_range(0, 15)), TAGLEN'($urandom_range(0, 3)), SETLEN'($urandom_range(0, 1)));
      CaptureEn = $urandom_range(0, 1) != 0;
      BusReady  = $urandom_range(0, 3) != 0;
      reset     = $urandom_range(0, 249) == 0;
      if (q_tag.size() != 0 && $urandom_range(0, 1) != 0) begin
        int k;
        k = $urandom_range(0, q_tag.size() - 1);
        LookupAdr = {q_tag[k], q_set[k]};
      end else begin
        LookupAdr = {TAGLEN'($urandom_range(0, 3)), SETLEN'($urandom_range(0, 1))};
      end
      cyc();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
